// File: rtl/test_completion_monitor_pkg.sv
// Shared types for the test-completion monitor: FSM states, verdict reason codes
// and a lowest-set-bit helper used to pick the reported failing channel.
package test_monitor_pkg;

  localparam int REASON_WIDTH = 2;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_e;

  typedef enum logic [REASON_WIDTH-1:0] {
    REASON_NONE      = 2'd0,
    REASON_TIMEOUT   = 2'd1,
    REASON_CHAN_FAIL = 2'd2,
    REASON_HANG      = 2'd3
  } reason_e;

  function automatic logic [4:0] lowestSetIndex(input logic [31:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/test_completion_monitor_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clear beats enable.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/test_completion_monitor.sv
// Test-completion monitor: holds the DUT in reset, then watches per-channel
// success/failure/progress and latches a sticky pass/fail verdict with its cause.
module test_completion_monitor
  import test_monitor_pkg::*;
#(
  parameter int NUM_CHANNELS      = 4,
  parameter int CYCLE_WIDTH       = 48,
  parameter int RESET_HOLD_CYCLES = 16,
  parameter int HANG_WIDTH        = 24,
  parameter bit REQUIRE_ALL       = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] chan_en_i,
  input  logic [NUM_CHANNELS-1:0] success_i,
  input  logic [NUM_CHANNELS-1:0] failure_i,
  input  logic [NUM_CHANNELS-1:0] progress_i,
  input  logic [CYCLE_WIDTH-1:0]  max_cycles_i,
  input  logic [HANG_WIDTH-1:0]   hang_limit_i,
  input  logic [CYCLE_WIDTH-1:0]  dump_start_i,
  output logic                    dut_reset_n_o,
  output logic                    dump_en_o,
  output logic                    done_o,
  output logic                    pass_o,
  output logic                    fail_o,
  output logic [REASON_WIDTH-1:0] reason_o,
  output logic [4:0]              fail_channel_o,
  output logic [CYCLE_WIDTH-1:0]  cycle_count_o
);

  localparam int HOLD_WIDTH = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(RESET_HOLD_CYCLES - 1);

  state_e                  state_q;
  logic [HOLD_WIDTH-1:0]   holdCount_q;
  logic [NUM_CHANNELS-1:0] latched_q;
  logic                    dutResetN_q;
  logic                    dumpEn_q;
  logic                    done_q;
  logic                    pass_q;
  logic                    fail_q;
  reason_e                 reason_q;
  logic [4:0]              failChannel_q;

  logic [CYCLE_WIDTH-1:0]  cycleCount;
  logic [HANG_WIDTH-1:0]   hangCount;
  logic                    running;
  logic [NUM_CHANNELS-1:0] chanSuccess;
  logic [NUM_CHANNELS-1:0] chanFail;
  logic [31:0]             failWide;
  logic                    progressAny;
  logic                    anyFail;
  logic                    timeoutHit;
  logic                    hangHit;
  logic                    passCond;
  logic                    dumpHit;
  logic                    verdictNow;
  logic [HANG_WIDTH:0]     hangNext;
  logic [CYCLE_WIDTH:0]    cycleNext;

  assign running     = (state_q == RUN);
  assign chanSuccess = success_i & chan_en_i;
  assign chanFail    = failure_i & chan_en_i;
  assign progressAny = |(progress_i & chan_en_i);
  assign anyFail     = |chanFail;

  always_comb begin
    failWide = '0;
    failWide[NUM_CHANNELS-1:0] = chanFail;
  end

  assign timeoutHit = (max_cycles_i != '0) && (cycleCount == max_cycles_i);

  // The current progress-free cycle counts toward the limit, so a limit of N
  // fires on the N-th consecutive cycle without enabled progress.
  assign hangNext = {1'b0, hangCount} + (HANG_WIDTH + 1)'(1);
  assign hangHit  = (hang_limit_i != '0) && !progressAny &&
                    (hangNext == {1'b0, hang_limit_i});

  assign passCond = REQUIRE_ALL
                  ? ((chan_en_i != '0) && (((latched_q | chanSuccess) & chan_en_i) == chan_en_i))
                  : (chanSuccess != '0);

  assign verdictNow = running && (anyFail || timeoutHit || hangHit || passCond);

  // dump_en is registered, so it is raised one edge early to be high while
  // cycle_count equals dump_start.
  assign cycleNext = {1'b0, cycleCount} + (CYCLE_WIDTH + 1)'(1);
  assign dumpHit   = (cycleNext == {1'b0, dump_start_i});

  sat_counter #(.WIDTH(CYCLE_WIDTH)) uCycleCounter (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (state_q == HOLD),
    .enable_i (running && !verdictNow),
    .count_o  (cycleCount)
  );

  sat_counter #(.WIDTH(HANG_WIDTH)) uHangCounter (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (!running || progressAny),
    .enable_i (running),
    .count_o  (hangCount)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= HOLD;
      holdCount_q   <= '0;
      latched_q     <= '0;
      dutResetN_q   <= 1'b0;
      dumpEn_q      <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      reason_q      <= REASON_NONE;
      failChannel_q <= '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (holdCount_q == HOLD_LAST) begin
            state_q     <= RUN;
            dutResetN_q <= 1'b1;
            dumpEn_q    <= (dump_start_i == '0);
          end else begin
            holdCount_q <= holdCount_q + HOLD_WIDTH'(1);
          end
        end
        RUN: begin
          latched_q <= latched_q | chanSuccess;
          if (anyFail) begin
            state_q       <= FAIL;
            done_q        <= 1'b1;
            fail_q        <= 1'b1;
            reason_q      <= REASON_CHAN_FAIL;
            failChannel_q <= lowestSetIndex(failWide);
            dumpEn_q      <= 1'b0;
          end else if (timeoutHit) begin
            state_q  <= FAIL;
            done_q   <= 1'b1;
            fail_q   <= 1'b1;
            reason_q <= REASON_TIMEOUT;
            dumpEn_q <= 1'b0;
          end else if (hangHit) begin
            state_q  <= FAIL;
            done_q   <= 1'b1;
            fail_q   <= 1'b1;
            reason_q <= REASON_HANG;
            dumpEn_q <= 1'b0;
          end else if (passCond) begin
            state_q  <= PASS;
            done_q   <= 1'b1;
            pass_q   <= 1'b1;
            reason_q <= REASON_NONE;
            dumpEn_q <= 1'b0;
          end else if (dumpHit) begin
            dumpEn_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign dut_reset_n_o  = dutResetN_q;
  assign dump_en_o      = dumpEn_q;
  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign fail_o         = fail_q;
  assign reason_o       = reason_q;
  assign fail_channel_o = failChannel_q;
  assign cycle_count_o  = cycleCount;

endmodule

// File: tb/tb_test_completion_monitor.sv
// Scoreboard bench for test_completion_monitor: each scenario pushes its expected
// verdict when the deciding stimulus is driven and pops it when done rises.
module tb_test_completion_monitor;

  localparam int NC   = 4;
  localparam int CW   = 48;
  localparam int HOLD = 16;
  localparam int HW   = 24;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [NC-1:0] chanEn, success, failure, progress;
  logic [CW-1:0] maxCycles, dumpStart;
  logic [HW-1:0] hangLimit;
  logic          dutResetN, dumpEn, done, pass, fail;
  logic [1:0]    reason;
  logic [4:0]    failChannel;
  logic [CW-1:0] cycleCount;

  typedef struct {
    logic        p;
    logic        f;
    logic [1:0]  r;
    logic [4:0]  ch;
    logic [63:0] cc;
  } verdict_t;

  verdict_t sbQ[$];
  int compareCount  = 0;
  int mismatchCount = 0;

  test_completion_monitor #(
    .NUM_CHANNELS(NC), .CYCLE_WIDTH(CW), .RESET_HOLD_CYCLES(HOLD),
    .HANG_WIDTH(HW), .REQUIRE_ALL(1'b1)
  ) dut (
    .clock(clock), .reset(reset),
    .chan_en_i(chanEn), .success_i(success), .failure_i(failure), .progress_i(progress),
    .max_cycles_i(maxCycles), .hang_limit_i(hangLimit), .dump_start_i(dumpStart),
    .dut_reset_n_o(dutResetN), .dump_en_o(dumpEn), .done_o(done), .pass_o(pass),
    .fail_o(fail), .reason_o(reason), .fail_channel_o(failChannel), .cycle_count_o(cycleCount)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic pushExpected(input logic p, input logic f, input logic [1:0] r,
                              input logic [4:0] ch, input int cc);
    verdict_t v;
    v.p = p; v.f = f; v.r = r; v.ch = ch; v.cc = 64'(cc);
    sbQ.push_back(v);
  endtask

  task automatic configure(input int sc);
    chanEn = 4'b1111; maxCycles = '0; hangLimit = '0; dumpStart = CW'(1000);
    case (sc)
      1: begin chanEn = 4'b0101; dumpStart = '0; end
      3, 4: maxCycles = CW'(100);
      5: begin chanEn = 4'b0011; hangLimit = HW'(20); end
      6: begin chanEn = 4'b0001; dumpStart = CW'(25); end
      7: chanEn = 4'b1110;
      default: begin end
    endcase
  endtask

  task automatic applyStimulus(input int sc, input int t);
    success = '0; failure = '0; progress = '0;
    case (sc)
      1: begin
        if (t == 10) success = 4'b0001;
        if (t == 20) success = 4'b0010;
        if (t == 30) begin success = 4'b0100; pushExpected(1'b1, 1'b0, 2'd0, 5'd0, 30); end
      end
      2: begin
        if (t == 5) success = 4'b0001;
        if (t == 6) success = 4'b0010;
        if (t == 7) success = 4'b0100;
        if (t == 50) begin
          success = 4'b1000; failure = 4'b1000;
          pushExpected(1'b0, 1'b1, 2'd2, 5'd3, 50);
        end
      end
      3: if (t == 100) pushExpected(1'b0, 1'b1, 2'd1, 5'd0, 100);
      4: if (t == 100) begin success = 4'b1111; pushExpected(1'b0, 1'b1, 2'd1, 5'd0, 100); end
      5: begin
        if (t > 0 && t <= 40 && (t % 10) == 0) progress = 4'b0001;
        if (t == 50) progress = 4'b0100;
        if (t == 60) pushExpected(1'b0, 1'b1, 2'd3, 5'd0, 60);
      end
      7: if (t == 12) begin failure = 4'b0011; pushExpected(1'b0, 1'b1, 2'd2, 5'd1, 12); end
      default: begin end
    endcase
  endtask

  task automatic checkVerdict(input verdict_t e, input string when);
    checkOutput({when, "_pass"}, 64'(pass), 64'(e.p));
    checkOutput({when, "_fail"}, 64'(fail), 64'(e.f));
    checkOutput({when, "_reason"}, 64'(reason), 64'(e.r));
    checkOutput({when, "_failChannel"}, 64'(failChannel), 64'(e.ch));
    checkOutput({when, "_cycleCount"}, 64'(cycleCount), e.cc);
    checkOutput({when, "_done"}, 64'(done), 64'd1);
    checkOutput({when, "_dutResetN"}, 64'(dutResetN), 64'd1);
    checkOutput({when, "_dumpEn"}, 64'(dumpEn), 64'd0);
  endtask

  task automatic checkResetState(input string when);
    checkOutput({when, "_flags"}, 64'({dutResetN, dumpEn, done, pass, fail, reason, failChannel}), 64'd0);
    checkOutput({when, "_cycleCount"}, 64'(cycleCount), 64'd0);
  endtask

  task automatic runScenario(input int sc, input int maxT, input bit expectVerdict);
    verdict_t e;
    bit finished = 1'b0;
    bit gotVerdict = 1'b0;
    reset = 1'b0;
    success = '0; failure = '0; progress = '0;
    configure(sc);
    repeat (2) begin @(posedge clock); #1; end
    checkResetState($sformatf("s%0d_reset", sc));
    reset = 1'b1;
    for (int k = 1; k <= HOLD; k++) begin
      @(posedge clock); #1;
      if (k == HOLD - 1) checkOutput($sformatf("s%0d_holdLow", sc), 64'(dutResetN), 64'd0);
    end
    checkOutput($sformatf("s%0d_dutResetRise", sc), 64'(dutResetN), 64'd1);

    for (int t = 0; t <= maxT && !finished; t++) begin
      if (done) begin
        finished = 1'b1;
        if (sbQ.size() == 0) begin
          checkOutput($sformatf("s%0d_earlyVerdict", sc), 64'(done), 64'd0);
        end else begin
          e = sbQ.pop_front();
          gotVerdict = 1'b1;
          checkVerdict(e, $sformatf("s%0d_verdict", sc));
        end
      end
      if (!finished) begin
        if (sc == 1 && t == 0) begin
          checkOutput("s1_dumpAtStart", 64'(dumpEn), 64'd1);
          checkOutput("s1_firstRunCount", 64'(cycleCount), 64'd0);
        end
        if (sc == 6 && t == 24) checkOutput("s6_dumpBefore", 64'(dumpEn), 64'd0);
        if (sc == 6 && t == 25) checkOutput("s6_dumpRise", 64'(dumpEn), 64'd1);
        applyStimulus(sc, t);
        @(posedge clock); #1;
      end
    end
    success = '0; failure = '0; progress = '0;

    if (expectVerdict && !finished) checkOutput($sformatf("s%0d_verdictTimeout", sc), 64'(done), 64'd1);

    if (gotVerdict) begin
      // Hammer the inputs after the verdict; everything must stay frozen.
      repeat (3) begin
        success = '1; failure = '1; progress = '1;
        @(posedge clock); #1;
      end
      success = '0; failure = '0; progress = '0;
      checkVerdict(e, $sformatf("s%0d_sticky", sc));
    end

    if (sc == 6) begin
      checkOutput("s6_countBeforeReset", 64'(cycleCount), 64'd41);
      reset = 1'b0;
      @(posedge clock); #1;
      checkResetState("s6_midRunReset");
    end
    sbQ.delete();
  endtask

  initial begin
    chanEn = '0; success = '0; failure = '0; progress = '0;
    maxCycles = '0; hangLimit = '0; dumpStart = '0;
    runScenario(1, 35, 1'b1);
    runScenario(2, 55, 1'b1);
    runScenario(3, 105, 1'b1);
    runScenario(4, 105, 1'b1);
    runScenario(5, 65, 1'b1);
    runScenario(6, 40, 1'b0);
    runScenario(7, 17, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
